// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant indexer.
// Optional feature macro used by the top: STICKY_GRANT_EN.
package arb_pkg;

  localparam int unsigned ARB_N     = 8;
  localparam int unsigned ARB_IDX_W = $clog2(ARB_N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Next index in round-robin order, wrapping n-1 -> 0.
  function automatic logic [ARB_IDX_W-1:0] wrap_inc(input logic [ARB_IDX_W-1:0] idx,
                                                    input int unsigned          n);
    return ARB_IDX_W'((32'(idx) + 32'd1) % n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotated first-one search: first set bit of req at or after start, wrapping mod N.
module rr_pick #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] pos;

  // Scan from the far end back toward start so the closest hit is written last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = start + IDX_W'(i);
      if (req[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_indexer.sv
// Round-robin arbiter emitting the winner as a binary index with valid/ready.
// Optional feature macro: STICKY_GRANT_EN (bounded back-to-back regrants).
module rr_grant_indexer
  import arb_pkg::*;
#(
  parameter int unsigned N         = ARB_N,
  parameter int unsigned IDX_W     = $clog2(N),
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             grant_ready,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic [IDX_W-1:0] ptr_dbg
);

  arb_state_t       state, state_d;
  logic [IDX_W-1:0] ptr, ptr_d;
  logic [IDX_W-1:0] idx_d;
  logic             valid_d;
  logic [IDX_W-1:0] ptr_next_c;
  logic [IDX_W-1:0] start_c;
  logic [IDX_W-1:0] pick_idx_c;
  logic             pick_found_c;
  logic             accept_c;

`ifdef STICKY_GRANT_EN
  localparam int unsigned BURST_W = IDX_W + 1;
  logic [BURST_W-1:0] burst_cnt, burst_d;
  logic               stay_c;
`endif

  assign ptr_dbg    = ptr;
  assign accept_c   = grant_valid & grant_ready;
  assign ptr_next_c = IDX_W'(wrap_inc(ARB_IDX_W'(grant_idx), N));
  // While a grant is out, the next search starts just past it so the
  // back-to-back winner is ready in the acceptance cycle.
  assign start_c    = (state == GRANT) ? ptr_next_c : ptr;

`ifdef STICKY_GRANT_EN
  assign stay_c = req[grant_idx] && (burst_cnt < BURST_W'(MAX_BURST - 1));
`endif

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .start (start_c),
    .idx   (pick_idx_c),
    .found (pick_found_c)
  );

  // State, pointer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
`ifdef STICKY_GRANT_EN
      burst_cnt   <= '0;
`endif
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      grant_idx   <= idx_d;
      grant_valid <= valid_d;
`ifdef STICKY_GRANT_EN
      burst_cnt   <= burst_d;
`endif
    end
  end

  // Next-state: issue from IDLE, hold while stalled, rotate or regrant on acceptance.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    idx_d   = grant_idx;
    valid_d = grant_valid;
`ifdef STICKY_GRANT_EN
    burst_d = burst_cnt;
`endif
    case (state)
      IDLE: begin
        if (pick_found_c) begin
          idx_d   = pick_idx_c;
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (accept_c) begin
`ifdef STICKY_GRANT_EN
          if (stay_c) begin
            burst_d = burst_cnt + BURST_W'(1);
          end else begin
            burst_d = '0;
`endif
            ptr_d = ptr_next_c;
            if (pick_found_c) begin
              idx_d = pick_idx_c;
            end else begin
              valid_d = 1'b0;
              state_d = IDLE;
            end
`ifdef STICKY_GRANT_EN
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_grant_indexer.sv
// Self-checking bench for rr_grant_indexer: directed literal checks plus a
// randomized run against a behavioural round-robin model.
module tb_rr_grant_indexer;

  localparam int NN = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NN-1:0] req;
  logic          grant_ready;
  logic [2:0]    grant_idx;
  logic          grant_valid;
  logic [2:0]    ptr_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model state.
  bit m_valid = 1'b0;
  int m_idx   = 0;
  int m_ptr   = 0;
  int m_burst = 0;

  rr_grant_indexer #(
    .N         (NN),
    .MAX_BURST (MB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant_ready (grant_ready),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .ptr_dbg     (ptr_dbg)
  );

  always #5 clk = ~clk;

  // First requester at or after start, modulo NN; -1 if none.
  function automatic int search(input logic [NN-1:0] r, input int start);
    for (int k = 0; k < NN; k++) begin
      if (r[(start + k) % NN]) return (start + k) % NN;
    end
    return -1;
  endfunction

  function automatic bit sticky_hold(input logic [NN-1:0] r, input int idx, input int burst);
`ifdef STICKY_GRANT_EN
    return r[idx] && (burst < MB - 1);
`else
    return 1'b0 & r[idx] & (burst < 0);
`endif
  endfunction

  // Reference behaviour evaluated at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_idx   <= 0;
      m_ptr   <= 0;
      m_burst <= 0;
    end else if (!m_valid) begin
      if (search(req, m_ptr) >= 0) begin
        m_valid <= 1'b1;
        m_idx   <= search(req, m_ptr);
      end
    end else if (grant_ready) begin
      if (sticky_hold(req, m_idx, m_burst)) begin
        m_burst <= m_burst + 1;
      end else begin
        m_burst <= 0;
        m_ptr   <= (m_idx + 1) % NN;
        if (search(req, (m_idx + 1) % NN) >= 0) m_idx <= search(req, (m_idx + 1) % NN);
        else m_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid", int'(grant_valid), int'(m_valid));
      chk("model_ptr", int'(ptr_dbg), m_ptr);
      if (m_valid) chk("model_idx", int'(grant_idx), m_idx);
    end
  end

  task automatic step(input logic [NN-1:0] r, input logic rd, input logic rs);
    req         = r;
    grant_ready = rd;
    rst         = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step('0, 1'b0, 1'b1);
  endtask

  int exp_seq[$];

  initial begin
    rst = 1'b1;
    req = '0;
    grant_ready = 1'b0;

    // Reset state.
    do_reset();
    chk_en = 1'b1;
    chk("reset_valid", int'(grant_valid), 0);
    chk("reset_idx", int'(grant_idx), 0);
    chk("reset_ptr", int'(ptr_dbg), 0);

    // Reset mid-grant drops the pending grant.
    step(8'hFF, 1'b0, 1'b0);
    chk("midgrant_valid_before", int'(grant_valid), 1);
    step(8'hFF, 1'b0, 1'b0);
    step(8'hFF, 1'b1, 1'b1);
    chk("midgrant_valid", int'(grant_valid), 0);
    chk("midgrant_idx", int'(grant_idx), 0);
    chk("midgrant_ptr", int'(ptr_dbg), 0);

`ifndef STICKY_GRANT_EN
    // Fairness with all requesting and ready held high.
    do_reset();
    exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    foreach (exp_seq[i]) begin
      step(8'hFF, 1'b1, 1'b0);
      chk("fair_idx", int'(grant_idx), exp_seq[i]);
      chk("fair_valid", int'(grant_valid), 1);
    end
    step(8'h00, 1'b1, 1'b0);
    chk("fair_drain_valid", int'(grant_valid), 0);
    chk("fair_drain_ptr", int'(ptr_dbg), 2);

    // Stall holds the grant; acceptance advances to the next requester.
    do_reset();
    step(8'b0001_0100, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(8'b0001_0100, 1'b0, 1'b0);
      chk("stall_idx", int'(grant_idx), 2);
      chk("stall_valid", int'(grant_valid), 1);
    end
    step(8'b0001_0100, 1'b1, 1'b0);
    chk("stall_next_idx", int'(grant_idx), 4);
    chk("stall_next_ptr", int'(ptr_dbg), 3);

    // Pointer wrap 7 -> search reaches requester 1.
    do_reset();
    step(8'b0100_0000, 1'b1, 1'b0);
    chk("wrap_first_idx", int'(grant_idx), 6);
    step(8'b0000_0010, 1'b1, 1'b0);
    chk("wrap_idx", int'(grant_idx), 1);
    chk("wrap_ptr", int'(ptr_dbg), 7);
    step(8'b0000_0000, 1'b1, 1'b0);
    chk("wrap_after_ptr", int'(ptr_dbg), 2);
    chk("wrap_after_valid", int'(grant_valid), 0);

    // Withdrawn request: grant is held until accepted, then FSM idles.
    do_reset();
    step(8'b0010_0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(8'b0000_0000, 1'b0, 1'b0);
      chk("withdraw_idx", int'(grant_idx), 5);
      chk("withdraw_valid", int'(grant_valid), 1);
    end
    step(8'b0000_0000, 1'b1, 1'b0);
    chk("withdraw_drop_valid", int'(grant_valid), 0);
    chk("withdraw_drop_ptr", int'(ptr_dbg), 6);
    step(8'b0000_0000, 1'b1, 1'b0);
    chk("withdraw_idle_valid", int'(grant_valid), 0);
    step(8'b0000_0001, 1'b0, 1'b0);
    chk("idle_regrant_valid", int'(grant_valid), 1);
    chk("idle_regrant_idx", int'(grant_idx), 0);
`else
    // Bounded sticky bursts alternate between two requesters.
    do_reset();
    exp_seq = '{0, 0, 0, 0, 3, 3, 3, 3, 0};
    foreach (exp_seq[i]) begin
      step(8'b0000_1001, 1'b1, 1'b0);
      chk("sticky_idx", int'(grant_idx), exp_seq[i]);
      chk("sticky_valid", int'(grant_valid), 1);
    end
`endif

    // Randomized traffic with stalls and occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [NN-1:0] r;
      if ($urandom_range(0, 3) == 0) r = '0;
      else r = NN'($urandom) & NN'($urandom);
      step(r, logic'($urandom_range(0, 9) < 6), logic'($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
